// File: rtl/alu_pkg.sv
// Shared ALU types and widths for the sequential right shifter and its helpers.
package alu_pkg;

  localparam int DATA_W   = 8;
  localparam int AMT_W    = 4;
  localparam int NARROW_W = 4;
  localparam int CNT_W    = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } shift_state_t;

  // Shifting past the operand width is the same as shifting by exactly the width.
  function automatic logic [CNT_W-1:0] sat_amt(input logic [AMT_W-1:0] amt);
    if (32'(amt) > DATA_W) return CNT_W'(DATA_W);
    else                   return CNT_W'(amt);
  endfunction

endpackage

// File: rtl/alu_shift_right_seq_if.sv
// Request/response bundle of the sequential right shifter.
interface alu_shift_right_seq_if;
  import alu_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic [DATA_W-1:0]   in_data;
  logic [AMT_W-1:0]    in_amt;
  logic                in_arith;
  logic                out_valid;
  logic                out_ready;
  logic [DATA_W-1:0]   out_data;
  logic [NARROW_W-1:0] out_narrow;
  logic                out_exact;
  logic                out_fits;

  modport master (
    output in_valid, in_data, in_amt, in_arith, out_ready,
    input  in_ready, out_valid, out_data, out_narrow, out_exact, out_fits
  );

  modport slave (
    input  in_valid, in_data, in_amt, in_arith, out_ready,
    output in_ready, out_valid, out_data, out_narrow, out_exact, out_fits
  );

endinterface

// File: rtl/alu_shift_step.sv
// One-bit right shift with fill selection and a sticky record of the bit shifted out.
module alu_shift_step
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] data_i,
  input  logic              arith_i,
  input  logic              sticky_i,
  output logic [DATA_W-1:0] data_next_o,
  output logic              sticky_o
);

  logic fill;

  assign fill        = arith_i & data_i[DATA_W-1];
  assign data_next_o = {fill, data_i[DATA_W-1:1]};
  assign sticky_o    = sticky_i | data_i[0];

endmodule

// File: rtl/alu_shift_right_seq.sv
// Multi-cycle right shifter: one bit per clock, reports whether the shift lost any set bits.
module alu_shift_right_seq
  import alu_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  alu_shift_right_seq_if.slave  bus
);

  shift_state_t      state_q, state_d;
  logic [DATA_W-1:0] data_q,  data_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic              sticky_q, sticky_d;
  logic              arith_q,  arith_d;

  logic [DATA_W-1:0] step_data;
  logic              step_sticky;
  logic [CNT_W-1:0]  req_amt;

  alu_shift_step u_step (
    .data_i      (data_q),
    .arith_i     (arith_q),
    .sticky_i    (sticky_q),
    .data_next_o (step_data),
    .sticky_o    (step_sticky)
  );

  assign req_amt = sat_amt(bus.in_amt);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      data_q   <= '0;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
      arith_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
      arith_q  <= arith_d;
    end
  end

  // NOTE: every signal gets a default first so no path through the case infers a latch.
  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    cnt_d    = cnt_q;
    sticky_d = sticky_q;
    arith_d  = arith_q;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          data_d   = bus.in_data;
          arith_d  = bus.in_arith;
          cnt_d    = req_amt;
          sticky_d = 1'b0;
          state_d  = (req_amt == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        data_d   = step_data;
        sticky_d = step_sticky;
        cnt_d    = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs come straight from flops; data_q is frozen while DONE waits for the consumer.
  assign bus.in_ready   = (state_q == IDLE);
  assign bus.out_valid  = (state_q == DONE);
  assign bus.out_data   = data_q;
  assign bus.out_narrow = data_q[NARROW_W-1:0];
  assign bus.out_exact  = ~sticky_q;
  assign bus.out_fits   = ~|data_q[DATA_W-1:NARROW_W];

endmodule

// File: tb/tb_alu_shift_right_seq.sv
// Directed and random checks of the sequential right shifter against an arithmetic model.
module tb_alu_shift_right_seq;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  alu_shift_right_seq_if bus ();

  alu_shift_right_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("comparison %s", tag);
    end
  endtask

  // Model: plain integer shifts on the saturated amount.
  task automatic ref_model(input logic [7:0] d, input int amt, input bit arith,
                           output logic [7:0] res, output bit exact, output bit fits,
                           output int n);
    int full;
    n = (amt > DATA_W) ? DATA_W : amt;
    if (arith) full = int'($signed(d)) >>> n;
    else       full = int'(d) >> n;
    res   = full[7:0];
    exact = ((int'(d) & ((1 << n) - 1)) == 0);
    fits  = (res[7:4] == 4'h0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request, wait for its result, apply backpressure, then consume it.
  task automatic run_req(input string tag, input logic [7:0] d, input int amt,
                         input bit arith, input int stall);
    logic [7:0] res;
    bit exact, fits;
    int n, lat;
    ref_model(d, amt, arith, res, exact, fits, n);
    check({tag, ".ready_before"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid  = 1'b1;
    bus.in_data   = d;
    bus.in_amt    = 4'(amt);
    bus.in_arith  = arith;
    bus.out_ready = 1'b0;
    step();
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      step();
      lat++;
    end
    check({tag, ".latency"}, 32'(lat),            32'(n + 1));
    check({tag, ".data"},    32'(bus.out_data),   32'(res));
    check({tag, ".narrow"},  32'(bus.out_narrow), 32'(res[3:0]));
    check({tag, ".exact"},   32'(bus.out_exact),  32'(exact));
    check({tag, ".fits"},    32'(bus.out_fits),   32'(fits));
    for (int k = 0; k < stall; k++) begin
      step();
      check({tag, ".hold_valid"}, 32'(bus.out_valid), 32'd1);
      check({tag, ".hold_data"},  32'(bus.out_data),  32'(res));
      check({tag, ".hold_ready"}, 32'(bus.in_ready),  32'd0);
    end
    check({tag, ".ready_in_done"}, 32'(bus.in_ready), 32'd0);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check({tag, ".consumed"}, 32'(bus.out_valid), 32'd0);
    check({tag, ".ready_after"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    logic [7:0] res_a, res_b, rd;
    bit ex_a, ex_b, ft_a, ft_b;
    int n_a, n_b, lat, ra;

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_amt    = '0;
    bus.in_arith  = 1'b0;
    bus.out_ready = 1'b0;

    #2;
    check("reset.ready", 32'(bus.in_ready),  32'd1);
    check("reset.valid", 32'(bus.out_valid), 32'd0);
    check("reset.data",  32'(bus.out_data),  32'd0);
    check("reset.exact", 32'(bus.out_exact), 32'd1);
    check("reset.fits",  32'(bus.out_fits),  32'd1);
    @(negedge clk);
    rst = 1'b0;
    step();

    // Directed cases with hand-derived expectations
    run_req("t1_logic_exact", 8'hB0, 4, 1'b0, 0);
    check("t1.data_const", 32'(bus.out_data), 32'h0B);
    run_req("t2_logic_inexact", 8'h2D, 3, 1'b0, 0);
    check("t2.data_const", 32'(bus.out_data), 32'h05);
    run_req("t3_arith_sat", 8'h90, 15, 1'b1, 0);
    check("t3.data_const", 32'(bus.out_data), 32'hFF);
    run_req("t4_zero_bp", 8'h5A, 0, 1'b0, 3);

    // Reset in the middle of a shift discards the operation
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hC3;
    bus.in_amt   = 4'd6;
    bus.in_arith = 1'b0;
    step();
    bus.in_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    #1;
    check("t5.ready",  32'(bus.in_ready),  32'd1);
    check("t5.valid",  32'(bus.out_valid), 32'd0);
    check("t5.data",   32'(bus.out_data),  32'd0);
    @(negedge clk);
    rst = 1'b0;
    step();
    check("t5.still_idle", 32'(bus.out_valid), 32'd0);
    run_req("t5_after_reset", 8'h80, 7, 1'b0, 0);
    check("t5.data_const", 32'(bus.out_data), 32'h01);

    // Back-to-back: in_valid stays high, consumer always ready
    ref_model(8'h6C, 2, 1'b0, res_a, ex_a, ft_a, n_a);
    ref_model(8'hE7, 5, 1'b1, res_b, ex_b, ft_b, n_b);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h6C;
    bus.in_amt    = 4'd2;
    bus.in_arith  = 1'b0;
    step();
    bus.in_data  = 8'hE7;
    bus.in_amt   = 4'd5;
    bus.in_arith = 1'b1;
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      step();
      lat++;
    end
    check("t6.a_latency", 32'(lat),           32'(n_a + 1));
    check("t6.a_data",    32'(bus.out_data),  32'(res_a));
    check("t6.a_exact",   32'(bus.out_exact), 32'(ex_a));
    step();
    check("t6.consume_valid", 32'(bus.out_valid), 32'd0);
    check("t6.consume_ready", 32'(bus.in_ready),  32'd1);
    step();
    check("t6.b_accepted", 32'(bus.in_ready), 32'd0);
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      step();
      lat++;
    end
    check("t6.b_latency", 32'(lat),           32'(n_b + 1));
    check("t6.b_data",    32'(bus.out_data),  32'(res_b));
    check("t6.b_exact",   32'(bus.out_exact), 32'(ex_b));
    check("t6.b_fits",    32'(bus.out_fits),  32'(ft_b));
    step();
    check("t6.b_consumed", 32'(bus.out_valid), 32'd0);
    step();
    check("t6.no_dup", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b0;

    // Random operands, amounts, modes and backpressure
    for (int i = 0; i < 24; i++) begin
      rd = 8'($urandom_range(0, 255));
      ra = int'($urandom_range(0, 15));
      run_req("rand", rd, ra, 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

endmodule
